inst_mem_resp: RTL

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/inst_mem_resp.sv
// Instruction memory with a byte-serial program loader and zero-latency fetch port.
// Optional fetch-address checking is enabled by defining INST_MEM_BOUNDS_EN.
module inst_mem_resp #(
    parameter int INST_MEM_DEPTH = 1024,
    parameter int INST_MEM_AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst_o,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        loading,
    output logic        addr_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    localparam logic [INST_MEM_AW-1:0] WPTR_MAX = INST_MEM_AW'(INST_MEM_DEPTH - 1);
    localparam logic [INST_MEM_AW-1:0] WPTR_ONE = INST_MEM_AW'(1);

    logic [31:0] mem [INST_MEM_DEPTH];

    state_t                 state_q, state_d;
    logic [INST_MEM_AW-1:0] wptr_q, wptr_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [23:0]            shift_q, shift_d;
    logic                   ld_done_q, ld_done_d;
    logic                   addr_err_q, addr_err_d;

    logic                   mem_we;
    logic [31:0]            mem_wdata;
    logic                   addr_ok;
    logic [INST_MEM_AW-1:0] rd_idx;

    // Handshake: a load byte transfers on a rising edge where ld_valid and ld_ready
    // are both high; ld_ready is simply "in S_LOAD", and ld_start wins over a byte.
    assign ld_ready = (state_q == S_LOAD);
    assign loading  = (state_q == S_LOAD);
    assign ld_done  = ld_done_q;
    assign rd_idx   = addr[INST_MEM_AW+1:2];

`ifdef INST_MEM_BOUNDS_EN
    assign addr_ok  = ((addr >> (INST_MEM_AW + 2)) == 32'd0) && (addr[1:0] == 2'b00);
    assign addr_err = addr_err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:INST_MEM_AW+2], addr[1:0], addr_err_q};
    assign addr_ok  = 1'b1;
    assign addr_err = 1'b0;
`endif

    always_comb begin
        inst_o = 32'h0;
        if (ce && (state_q == S_IDLE) && !rst && addr_ok) begin
            inst_o = mem[rd_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        ld_done_d  = 1'b0;
        addr_err_d = addr_err_q;
        mem_we     = 1'b0;
        mem_wdata  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (ce && !addr_ok) begin
                    addr_err_d = 1'b1;
                end
                if (ld_start) begin
                    state_d    = S_LOAD;
                    wptr_d     = '0;
                    byte_cnt_d = 2'd0;
                    shift_d    = 24'h0;
                end
            end
            S_LOAD: begin
                if (ld_start) begin
                    wptr_d     = '0;
                    byte_cnt_d = 2'd0;
                    shift_d    = 24'h0;
                end else if (ld_valid) begin
                    // Earlier bytes sit right-aligned in shift_q; a short final word pads low bytes.
                    case (byte_cnt_q)
                        2'd0:    mem_wdata = {ld_data, 24'h0};
                        2'd1:    mem_wdata = {shift_q[7:0], ld_data, 16'h0};
                        2'd2:    mem_wdata = {shift_q[15:0], ld_data, 8'h0};
                        default: mem_wdata = {shift_q[23:0], ld_data};
                    endcase
                    if ((byte_cnt_q == 2'd3) || ld_last) begin
                        mem_we     = 1'b1;
                        byte_cnt_d = 2'd0;
                        shift_d    = 24'h0;
                        if (wptr_q == WPTR_MAX) begin
                            state_d   = S_IDLE;
                            ld_done_d = 1'b1;
                        end else begin
                            wptr_d = wptr_q + WPTR_ONE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        shift_d    = {shift_q[15:0], ld_data};
                    end
                    if (ld_last) begin
                        state_d   = S_IDLE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'h0;
            ld_done_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            ld_done_q  <= ld_done_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Contents survive reset; a write coinciding with reset is dropped with the load.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wptr_q] <= mem_wdata;
        end
    end

endmodule
